// File: rtl/am2909_pkg.sv
// Shared constants for the am2909 microprogram sequencer: source-select
// encodings and default bus width / stack depth.
package am2909_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    SEL_UPC = 2'b00,
    SEL_AR  = 2'b01,
    SEL_STK = 2'b10,
    SEL_D   = 2'b11
  } sel_e;

endpackage

// File: rtl/am2909_stack.sv
// Wrapping file stack: stack pointer plus register file, push/pop/hold with
// asynchronous clear. Top of stack is always mem[sp].
module am2909_stack
  import am2909_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fe,
  input  logic             pup,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    sp;
  logic [PW-1:0]    sp_inc;
  logic [PW-1:0]    sp_dec;
  logic [WIDTH-1:0] mem [DEPTH];

  // DEPTH is a power of two, so plain PW-bit arithmetic gives the wrap.
  assign sp_inc = sp + PW'(1);
  assign sp_dec = sp - PW'(1);
  assign top    = mem[sp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!fe) begin
      if (pup) begin
        sp          <= sp_inc;
        mem[sp_inc] <= push_data;
      end else begin
        sp <= sp_dec;
      end
    end
  end

endmodule

// File: rtl/am2909.sv
// am2909 microprogram sequencer slice: source mux, OR/ZERO shaping,
// tri-state output, address register, microprogram counter and file stack.
module am2909
  import am2909_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             FE,
  input  logic             PUP,
  input  logic             RE,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] R,
  input  logic [1:0]       S,
  input  logic             OE,
  input  logic             CP,
  input  logic [WIDTH-1:0] OR,
  input  logic             ZERO,
  input  logic             C,
  output logic [WIDTH-1:0] Y,
  input  logic             RST_N
);

  logic [WIDTH-1:0] upc;
  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] stk_top;
  logic [WIDTH-1:0] mux;
  logic [WIDTH-1:0] next_addr;

  always_comb begin
    mux = upc;
    case (sel_e'(S))
      SEL_UPC: mux = upc;
      SEL_AR:  mux = ar;
      SEL_STK: mux = stk_top;
      SEL_D:   mux = D;
      default: mux = upc;
    endcase
  end

  // ZERO wins over the OR mask; the incrementer sees this shaped value.
  assign next_addr = ZERO ? (mux | OR) : '0;
  assign Y         = OE ? {WIDTH{1'bz}} : next_addr;

  always_ff @(posedge CP or negedge RST_N) begin
    if (!RST_N) begin
      ar <= '0;
    end else if (!RE) begin
      ar <= R;
    end
  end

  always_ff @(posedge CP or negedge RST_N) begin
    if (!RST_N) begin
      upc <= '0;
    end else begin
      upc <= C ? next_addr : next_addr + WIDTH'(1);
    end
  end

  am2909_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_stack (
    .clk      (CP),
    .rst_n    (RST_N),
    .fe       (FE),
    .pup      (PUP),
    .push_data(upc),
    .top      (stk_top)
  );

endmodule

// File: tb/tb_am2909.sv
// Self-checking bench for am2909: directed vector table, hand-written stack
// wrap / output-enable / reset sequences, and a randomized run against a model.
module tb_am2909;

  logic       cp;
  logic       rst_n;
  logic       fe, pup, re, oe, zero, c;
  logic [3:0] d, r, orm;
  logic [1:0] s;
  wire  [3:0] y;

  int checks = 0;
  int errors = 0;

  am2909 #(.WIDTH(4), .DEPTH(4)) dut (
    .FE(fe), .PUP(pup), .RE(re), .D(d), .R(r), .S(s), .OE(oe), .CP(cp),
    .OR(orm), .ZERO(zero), .C(c), .Y(y), .RST_N(rst_n)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  typedef struct {
    logic       fe, pup, re;
    logic [3:0] d, r;
    logic [1:0] s;
    logic [3:0] orm;
    logic       zero, c;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mkv(input logic fe_i, input logic pup_i, input logic re_i,
                               input logic [3:0] d_i, input logic [3:0] r_i,
                               input logic [1:0] s_i, input logic [3:0] or_i,
                               input logic zero_i, input logic c_i, input logic [3:0] exp_i);
    vec_t v;
    v.fe = fe_i; v.pup = pup_i; v.re = re_i; v.d = d_i; v.r = r_i; v.s = s_i;
    v.orm = or_i; v.zero = zero_i; v.c = c_i; v.exp = exp_i;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic fe_i, input logic pup_i, input logic re_i,
                       input logic [3:0] d_i, input logic [3:0] r_i, input logic [1:0] s_i,
                       input logic oe_i, input logic [3:0] or_i, input logic zero_i,
                       input logic c_i);
    fe = fe_i; pup = pup_i; re = re_i; d = d_i; r = r_i; s = s_i;
    oe = oe_i; orm = or_i; zero = zero_i; c = c_i;
  endtask

  task automatic do_reset();
    @(negedge cp);
    rst_n = 1'b0;
    #1;
    check("reset_y", y, 4'b0000);
    @(negedge cp);
    rst_n = 1'b1;
  endtask

  // Reference model state
  int m_upc, m_ar, m_sp;
  int m_stk[4];

  initial begin
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 2'b11, 1'b0, 4'h0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_y", y, 4'b0000);
    #10;
    rst_n = 1'b1;

    // Directed table: applied at negedge, Y checked 1 ns later, then one edge.
    tbl[0]  = mkv(1, 0, 1, 4'h0, 4'h0, 2'b11, 4'h0, 1, 0, 4'h0);
    tbl[1]  = mkv(1, 0, 1, 4'h0, 4'h0, 2'b00, 4'h0, 1, 0, 4'h1);
    tbl[2]  = mkv(1, 0, 1, 4'h0, 4'h0, 2'b00, 4'h0, 1, 0, 4'h2);
    tbl[3]  = mkv(1, 0, 1, 4'h0, 4'h0, 2'b00, 4'h0, 1, 1, 4'h3);
    tbl[4]  = mkv(1, 0, 1, 4'h0, 4'h0, 2'b00, 4'h0, 1, 1, 4'h3);
    tbl[5]  = mkv(0, 1, 1, 4'h0, 4'h0, 2'b00, 4'h0, 1, 0, 4'h3);
    tbl[6]  = mkv(1, 0, 1, 4'h0, 4'h0, 2'b10, 4'h0, 1, 1, 4'h3);
    tbl[7]  = mkv(1, 0, 0, 4'h0, 4'hA, 2'b01, 4'h0, 1, 1, 4'h0);
    tbl[8]  = mkv(1, 0, 1, 4'h0, 4'h5, 2'b01, 4'h0, 1, 1, 4'hA);
    tbl[9]  = mkv(1, 0, 1, 4'h0, 4'h5, 2'b01, 4'hF, 1, 1, 4'hF);
    tbl[10] = mkv(1, 0, 1, 4'h0, 4'h5, 2'b01, 4'hF, 0, 0, 4'h0);
    tbl[11] = mkv(0, 0, 1, 4'h0, 4'h0, 2'b00, 4'h0, 1, 1, 4'h1);
    tbl[12] = mkv(1, 0, 1, 4'h0, 4'h0, 2'b10, 4'h0, 1, 1, 4'h0);
    tbl[13] = mkv(1, 0, 1, 4'hF, 4'h0, 2'b11, 4'h0, 1, 0, 4'hF);
    tbl[14] = mkv(1, 0, 1, 4'h0, 4'h0, 2'b00, 4'h0, 1, 1, 4'h0);
    for (int i = 0; i < 15; i++) begin
      @(negedge cp);
      drive(tbl[i].fe, tbl[i].pup, tbl[i].re, tbl[i].d, tbl[i].r, tbl[i].s, 1'b0,
            tbl[i].orm, tbl[i].zero, tbl[i].c);
      #1;
      check($sformatf("tbl_%0d", i), y, tbl[i].exp);
    end

    // Output enable: state must survive a tri-stated cycle.
    @(negedge cp);
    drive(1, 0, 1, 4'h6, 4'h0, 2'b11, 1'b0, 4'h0, 1, 1);
    @(negedge cp);
    drive(1, 0, 1, 4'h0, 4'h0, 2'b00, 1'b1, 4'h0, 1, 1);
    @(negedge cp);
    oe = 1'b0;
    #1;
    check("oe_restore", y, 4'h6);

    // Five pushes on a depth-4 stack, then pop back down through the wrap.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge cp);
      drive(0, 1, 1, 4'h0, 4'h0, 2'b00, 1'b0, 4'h0, 1, 0);
      #1;
      check($sformatf("push_upc_%0d", i), y, 4'(i));
    end
    begin
      logic [3:0] pop_exp[5];
      pop_exp[0] = 4'h4; pop_exp[1] = 4'h3; pop_exp[2] = 4'h2;
      pop_exp[3] = 4'h1; pop_exp[4] = 4'h4;
      for (int i = 0; i < 5; i++) begin
        @(negedge cp);
        drive(0, 0, 1, 4'h0, 4'h0, 2'b10, 1'b0, 4'h0, 1, 1);
        #1;
        check($sformatf("pop_top_%0d", i), y, pop_exp[i]);
      end
    end

    // Mid-run asynchronous reset clears AR immediately.
    @(negedge cp);
    drive(1, 0, 0, 4'h0, 4'h9, 2'b01, 1'b0, 4'h0, 1, 1);
    @(negedge cp);
    re = 1'b1;
    #1;
    check("ar_loaded", y, 4'h9);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_async_clear", y, 4'h0);
    @(negedge cp);
    rst_n = 1'b1;

    // Randomized run against a behavioural model; state is all zero here.
    m_upc = 0; m_ar = 0; m_sp = 0;
    for (int i = 0; i < 4; i++) m_stk[i] = 0;
    for (int n = 0; n < 400; n++) begin
      int mx, nx;
      @(negedge cp);
      drive(($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom), 4'($urandom),
            4'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
            ($urandom_range(0, 7) != 0), 1'($urandom));
      case (s)
        2'b00:   mx = m_upc;
        2'b01:   mx = m_ar;
        2'b10:   mx = m_stk[m_sp];
        default: mx = int'(d);
      endcase
      nx = zero ? (mx | int'(orm)) : 0;
      #1;
      if (!oe) check($sformatf("rand_%0d", n), y, 4'(nx));
      if (!re) m_ar = int'(r);
      if (!fe) begin
        if (pup) begin
          m_sp = (m_sp + 1) % 4;
          m_stk[m_sp] = m_upc;
        end else begin
          m_sp = (m_sp + 3) % 4;
        end
      end
      m_upc = c ? nx : (nx + 1) % 16;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
